alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl_pkg.sv | 40 ++++
 rtl/alu_issue_ctrl_if.sv | 28 ++
 rtl/alu_issue_ctrl_lat_counter.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: op codes, FSM states and
// the op-code to one-hot ALU control mapping.
package alu_pkg;

    localparam int ONEHOT_W = 12;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_SHR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;
    localparam logic [3:0] OP_NEG = 4'd10;
    localparam logic [3:0] OP_NOT = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_NOT;
    endfunction

    // Codes 12-15 have no ALU control line and map to all-zero.
    function automatic logic [ONEHOT_W-1:0] op_onehot(input logic [3:0] op);
        logic [ONEHOT_W-1:0] oh;
        oh = '0;
        if (op_legal(op)) begin
            oh = ONEHOT_W'(1) << op;
        end
        return oh;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response bundle between the control unit (master) and the ALU
// issue controller (slave).
interface alu_issue_ctrl_if #(
    parameter int BITS = 32
) ();

    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_op;
    logic [BITS-1:0] req_x;
    logic [BITS-1:0] req_y;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [BITS-1:0] z_hi;
    logic [BITS-1:0] z_lo;
    logic            rsp_err;

    modport master (
        output req_valid, req_op, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, z_hi, z_lo, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, z_hi, z_lo, rsp_err
    );

endinterface

// File: rtl/alu_issue_ctrl_lat_counter.sv
// Loadable down-counter used to time how long the ALU controls are held.
module alu_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential issue controller for the datapath ALU: one op in flight, result
// captured into z_hi/z_lo. Optional counters enabled by ALU_ISSUE_STATS_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int BITS    = 32,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic                  clk,
    input  logic                  clr_n,
    alu_issue_ctrl_if.slave       bus,
    output logic [ONEHOT_W-1:0]   ctrl_signal,
    output logic [BITS-1:0]       alu_x,
    output logic [BITS-1:0]       alu_y,
`ifdef ALU_ISSUE_STATS_EN
    output logic [31:0]           stat_ops,
    output logic [15:0]           stat_err,
`endif
    input  logic [2*BITS-1:0]     alu_result
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [BITS-1:0] x_q, x_d;
    logic [BITS-1:0] y_q, y_d;
    logic [BITS-1:0] z_hi_q, z_hi_d;
    logic [BITS-1:0] z_lo_q, z_lo_d;
    logic            err_q, err_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_count;
    logic             cnt_zero;

    function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] op);
        case (op)
            OP_MUL:  return CNT_W'(MUL_LAT - 1);
            OP_DIV:  return CNT_W'(DIV_LAT - 1);
            default: return '0;
        endcase
    endfunction

    alu_lat_counter #(.W(CNT_W)) u_lat (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        x_d          = x_q;
        y_d          = y_q;
        z_hi_d       = z_hi_q;
        z_lo_d       = z_lo_q;
        err_d        = err_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d = bus.req_op;
                    x_d  = bus.req_x;
                    y_d  = bus.req_y;
                    // Bad requests are answered straight away; the ALU never sees them.
                    if (!op_legal(bus.req_op) ||
                        ((bus.req_op == OP_DIV) && (bus.req_y == '0))) begin
                        state_d = ST_RESP;
                        z_hi_d  = '0;
                        z_lo_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d      = ST_EXEC;
                        cnt_load     = 1'b1;
                        cnt_load_val = lat_m1(bus.req_op);
                    end
                end
            end
            ST_EXEC: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    z_hi_d  = alu_result[2*BITS-1:BITS];
                    z_lo_d  = alu_result[BITS-1:0];
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_hi_q  <= '0;
            z_lo_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_hi_q  <= z_hi_d;
            z_lo_q  <= z_lo_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.z_hi      = z_hi_q;
    assign bus.z_lo      = z_lo_q;
    assign bus.rsp_err   = err_q;
    assign ctrl_signal   = (state_q == ST_EXEC) ? op_onehot(op_q) : '0;
    assign alu_x         = x_q;
    assign alu_y         = y_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_ops_q, stat_ops_d;
    logic [15:0] stat_err_q, stat_err_d;
    logic        rsp_hs;

    assign rsp_hs = (state_q == ST_RESP) && bus.rsp_ready;

    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_err_d = stat_err_q;
        if (rsp_hs && !err_q && (stat_ops_q != '1)) begin
            stat_ops_d = stat_ops_q + 32'd1;
        end
        if (rsp_hs && err_q && (stat_err_q != '1)) begin
            stat_err_d = stat_err_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stat_ops_q <= '0;
            stat_err_q <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU that only
// produces a valid result once its controls have been held long enough.
module tb_alu_issue_ctrl;

    localparam int BITS    = 32;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [11:0] ctrl_signal;
    logic [31:0] alu_x, alu_y;
    logic [63:0] alu_result;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_ops;
    logic [15:0] stat_err;
`endif

    alu_issue_ctrl_if #(.BITS(BITS)) bus ();

    alu_issue_ctrl #(.BITS(BITS), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .bus         (bus),
        .ctrl_signal (ctrl_signal),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
`ifdef ALU_ISSUE_STATS_EN
        .stat_ops    (stat_ops),
        .stat_err    (stat_err),
`endif
        .alu_result  (alu_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural ALU ----------------
    int          hold;
    int          need;
    logic [31:0] garb;
    logic [63:0] sx, sy, prod, dbl_r, dbl_l;
    logic [31:0] quo, rem;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) hold <= 0;
        else if (ctrl_signal != 12'h000) hold <= hold + 1;
        else hold <= 0;
    end

    assign garb  = 32'hDEAD0000 ^ 32'(cyc);
    assign sx    = {{32{alu_x[31]}}, alu_x};
    assign sy    = {{32{alu_y[31]}}, alu_y};
    assign prod  = sx * sy;
    assign quo   = (alu_y == 0) ? 32'h0 : 32'($signed(alu_x) / $signed(alu_y));
    assign rem   = (alu_y == 0) ? 32'h0 : 32'($signed(alu_x) % $signed(alu_y));
    assign dbl_r = {alu_x, alu_x} >> alu_y[4:0];
    assign dbl_l = {alu_x, alu_x} << alu_y[4:0];

    always_comb begin
        need = (ctrl_signal == 12'h004) ? MUL_LAT : (ctrl_signal == 12'h008) ? DIV_LAT : 1;
        case (ctrl_signal)
            12'h001: alu_result = {32'h0, alu_x + alu_y};
            12'h002: alu_result = {32'h0, alu_x - alu_y};
            12'h004: alu_result = prod;
            12'h008: alu_result = {rem, quo};
            12'h010: alu_result = {32'h0, alu_x >> alu_y[4:0]};
            12'h020: alu_result = {32'h0, alu_x << alu_y[4:0]};
            12'h040: alu_result = {32'h0, dbl_r[31:0]};
            12'h080: alu_result = {32'h0, dbl_l[63:32]};
            12'h100: alu_result = {32'h0, alu_x & alu_y};
            12'h200: alu_result = {32'h0, alu_x | alu_y};
            12'h400: alu_result = {32'h0, 32'h0 - alu_x};
            12'h800: alu_result = {32'h0, ~alu_x};
            default: alu_result = {garb, ~garb};
        endcase
        if (hold < need - 1) alu_result = {~garb, garb};
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          lat;
        logic [11:0] ctrl;
        logic [31:0] x;
        logic [31:0] y;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor samples just after the falling edge, when all inputs are settled.
    exp_t cur;
    logic seen = 1'b0;
    int   exec_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!clr_n) begin
                seen     = 1'b0;
                exec_cnt = 0;
            end else begin
                if (ctrl_signal != 12'h000) begin
                    exec_cnt++;
                    if (exp_q.size() == 0 || seen) begin
                        chk("ctrl_unexpected", {52'h0, ctrl_signal}, 64'h0);
                    end else begin
                        chk("ctrl_onehot", {52'h0, ctrl_signal}, {52'h0, exp_q[0].ctrl});
                        chk("alu_x_hold", {32'h0, alu_x}, {32'h0, exp_q[0].x});
                        chk("alu_y_hold", {32'h0, alu_y}, {32'h0, exp_q[0].y});
                    end
                end
                if (bus.rsp_valid) begin
                    if (!seen) begin
                        if (exp_q.size() == 0) begin
                            chk("rsp_unexpected", 64'h1, 64'h0);
                        end else begin
                            cur  = exp_q.pop_front();
                            seen = 1'b1;
                            chk("rsp_latency", 64'(cyc), 64'(cur.acc + cur.lat));
                            chk("exec_cycles", 64'(exec_cnt), 64'(cur.lat));
                        end
                    end
                    if (seen) begin
                        chk("z_hi", {32'h0, bus.z_hi}, {32'h0, cur.hi});
                        chk("z_lo", {32'h0, bus.z_lo}, {32'h0, cur.lo});
                        chk("rsp_err", {63'h0, bus.rsp_err}, {63'h0, cur.err});
                        chk("ctrl_in_resp", {52'h0, ctrl_signal}, 64'h0);
                    end
                    if (bus.rsp_ready) begin
                        seen     = 1'b0;
                        exec_cnt = 0;
                        hs_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] hi, input logic [31:0] lo, input logic err,
                         input int lat, input logic [11:0] ctrl);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("req_ready_timeout", 64'h0, 64'h1);
        bus.req_op    = op;
        bus.req_x     = x;
        bus.req_y     = y;
        bus.req_valid = 1'b1;
        e.hi = hi; e.lo = lo; e.err = err; e.lat = lat; e.ctrl = ctrl;
        e.x = x; e.y = y; e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = 4'hF;
        bus.req_x     = 32'h5A5A5A5A;
        bus.req_y     = 32'h0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(bus.req_ready && exp_q.size() == 0 && !seen) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 64'h0, 64'h1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {63'h0, bus.req_ready}, 64'h1);
        chk({tag, "_rsp_valid"}, {63'h0, bus.rsp_valid}, 64'h0);
        chk({tag, "_ctrl"}, {52'h0, ctrl_signal}, 64'h0);
        chk({tag, "_alu_xy"}, {alu_x, alu_y}, 64'h0);
        chk({tag, "_z"}, {bus.z_hi, bus.z_lo}, 64'h0);
        chk({tag, "_err"}, {63'h0, bus.rsp_err}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int n;
        clr_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'h0;
        bus.req_x     = 32'h0;
        bus.req_y     = 32'h0;
        bus.rsp_ready = 1'b1;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        issue(4'd0,  32'd3,         32'd5,          32'h0, 32'd8,          1'b0, 1, 12'h001);
        issue(4'd1,  32'd10,        -32'sd10,       32'h0, 32'd20,         1'b0, 1, 12'h002);
        issue(4'd1,  -32'sd15,      -32'sd5,        32'h0, 32'hFFFFFFF6,   1'b0, 1, 12'h002);
        issue(4'd2,  -32'sd15,      32'd5,   32'hFFFFFFFF, 32'hFFFFFFB5,   1'b0, MUL_LAT, 12'h004);
        issue(4'd3,  -32'sd15,      -32'sd5,        32'h0, 32'd3,          1'b0, DIV_LAT, 12'h008);
        issue(4'd3,  32'd77,        32'd0,          32'h0, 32'h0,          1'b1, 0, 12'h000);
        issue(4'd13, 32'd1,         32'd2,          32'h0, 32'h0,          1'b1, 0, 12'h000);
        issue(4'd4,  32'h80,        32'd3,          32'h0, 32'h10,         1'b0, 1, 12'h010);
        issue(4'd5,  32'd1,         32'd4,          32'h0, 32'h10,         1'b0, 1, 12'h020);
        issue(4'd6,  32'd1,         32'd1,          32'h0, 32'h80000000,   1'b0, 1, 12'h040);
        issue(4'd7,  32'h80000001,  32'd4,          32'h0, 32'h18,         1'b0, 1, 12'h080);
        issue(4'd9,  32'hF0,        32'h0F,         32'h0, 32'hFF,         1'b0, 1, 12'h200);
        issue(4'd10, 32'd5,         32'd0,          32'h0, 32'hFFFFFFFB,   1'b0, 1, 12'h400);
        issue(4'd11, 32'd0,         32'd0,          32'h0, 32'hFFFFFFFF,   1'b0, 1, 12'h800);
        wait_idle();

        // Backpressure: response held while a competing request is offered.
        bus.rsp_ready = 1'b0;
        issue(4'd8, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1'b0, 1, 12'h100);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = 4'd0;
            bus.req_x     = 32'd1;
            bus.req_y     = 32'd1;
            #1;
            chk("bp_req_ready", {63'h0, bus.req_ready}, 64'h0);
            chk("bp_rsp_valid", {63'h0, bus.rsp_valid}, 64'h1);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        hs0 = hs_cnt;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("bp_handshakes", 64'(hs_cnt), 64'(hs0 + 1));
        chk("bp_back_idle", {63'h0, bus.req_ready}, 64'h1);
        chk("bp_no_extra_rsp", {63'h0, bus.rsp_valid}, 64'h0);
        wait_idle();

        // Asynchronous reset in the middle of a divide.
        issue(4'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT, 12'h008);
        repeat (2) @(negedge clk);
        clr_n = 1'b0;
        #1;
        exp_q.delete();
        chk_reset_outputs("midreset");
        @(negedge clk);
        clr_n = 1'b1;
        issue(4'd0, 32'd3, 32'd5, 32'h0, 32'd8, 1'b0, 1, 12'h001);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
